mul_div_unit: RTL and testbench

Iterative multiply/divide unit holding the architectural HI/LO registers. It executes the one-hot `div_mul_control` operation produced by instruction decode. It receives operands in EX, runs a 32-iteration shift-add or restoring-division sequence, then writes HI/LO. It also serves MTHI/MTLO writes and exposes HI/LO to the MFHI/MFLO write-back path.

---
 rtl/mdu_pkg.sv | 55 +++++
 rtl/mul_div_unit_if.sv | 38 +++
 rtl/mul_div_unit_div_iter.sv | 29 ++
 rtl/mul_div_unit.sv | 187 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit: iteration count,
// decode op-bit positions, FSM state encoding and small helper functions used
// when latching a new operation.
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_ITERS = 32;
    localparam int CNT_W     = $clog2(MDU_ITERS);

    // Index of the final iteration; reaching it means the counter wraps next.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MDU_ITERS - 1);

    // Bit positions in decode's one-hot div_mul_control vector.
    localparam int OP_DIV   = 0;
    localparam int OP_DIVU  = 1;
    localparam int OP_MULT  = 2;
    localparam int OP_MULTU = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mdu_state_e;

    // Operation class after priority resolution of the op vector.
    typedef struct packed {
        logic is_div;
        logic is_signed;
    } mdu_op_t;

    // Priority div > divu > mult > multu when decode sets more than one bit.
    function automatic mdu_op_t decode_op(input logic [3:0] op);
        mdu_op_t r;
        r.is_div    = 1'b0;
        r.is_signed = 1'b0;
        if (op[OP_DIV]) begin
            r.is_div    = 1'b1;
            r.is_signed = 1'b1;
        end else if (op[OP_DIVU]) begin
            r.is_div    = 1'b1;
        end else if (op[OP_MULT]) begin
            r.is_signed = 1'b1;
        end
        return r;
    endfunction

    // Magnitude of a two's-complement value when treated as signed; the
    // iteration datapath works on magnitudes and fixes signs in FIN.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_if
// Request / result bundle between the EX stage (master) and the multiply/divide
// unit (slave).
//   req_valid/req_ready : operation handshake, op is decode's one-hot vector
//   src1/src2           : rs / rt operand values
//   flush               : exception/ERET cancel of any in-flight operation
//   hi_wen/lo_wen/wdata : MTHI / MTLO writes
//   busy/done           : operation in flight / one-cycle completion pulse
//   hi/lo               : architectural HI/LO register values
// -----------------------------------------------------------------------------
interface mul_div_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        hi_wen;
    logic        lo_wen;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req_valid, op, src1, src2, flush, hi_wen, lo_wen, wdata,
        input  req_ready, busy, done, hi, lo
    );

    modport slave (
        input  req_valid, op, src1, src2, flush, hi_wen, lo_wen, wdata,
        output req_ready, busy, done, hi, lo
    );

endinterface

// File: rtl/mul_div_unit_div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// One radix-2 restoring division step. The dividend is held in the quotient
// register and shifts out of its MSB into the partial remainder while the new
// quotient bit shifts in at the LSB.
//   rem_in/rem_out : 33-bit partial remainder before / after the step
//   quo_in/quo_out : dividend-then-quotient shift register
//   divisor        : divisor magnitude
// -----------------------------------------------------------------------------
module div_iter (
    input  logic [32:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [32:0] rem_out,
    output logic [31:0] quo_out
);

    // One extra bit beyond the shifted remainder so its MSB is the borrow.
    logic [33:0] diff;
    logic        borrow;

    assign diff    = {rem_in, quo_in[31]} - {2'b00, divisor};
    assign borrow  = diff[33];

    // Restore (keep the shifted value) when the trial subtraction underflows.
    assign rem_out = borrow ? {rem_in[31:0], quo_in[31]} : diff[32:0];
    assign quo_out = {quo_in[30:0], ~borrow};

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// An accepted op runs 32 shift-add (multiply) or restoring-division steps on
// operand magnitudes, applies sign correction in FIN and writes HI/LO.
// MTHI/MTLO writes land directly in HI/LO except on the FIN edge.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   mdu    : request/result bundle (slave side)
// -----------------------------------------------------------------------------
module mul_div_unit
    import mdu_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    mul_div_unit_if.slave  mdu
);

    mdu_state_e       state;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_res;   // operand signs differ (signed ops only)
    logic             neg_rem;   // signed dividend was negative
    logic             div_zero;  // divisor was zero

    // Shared iteration registers:
    //   acc   : upper product half (mult) / partial remainder (div)
    //   a_reg : multiplier, lower product half (mult) / dividend -> quotient (div)
    //   b_reg : multiplicand (mult) / divisor (div)
    logic [32:0]      acc;
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;

    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    mdu_op_t          dec;
    logic             accept;
    logic [32:0]      mul_sum;
    logic [32:0]      div_rem;
    logic [31:0]      div_quo;
    logic [63:0]      prod_mag;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    assign dec    = decode_op(mdu.op);
    assign accept = (state == IDLE) && mdu.req_valid && (|mdu.op) && !mdu.flush;

    // Multiply step: conditionally add the multiplicand to the upper half, then
    // shift the whole 64-bit {acc, a_reg} product right by one.
    assign mul_sum = {1'b0, acc[31:0]} + (a_reg[0] ? {1'b0, b_reg} : 33'd0);

    div_iter u_div_iter (
        .rem_in  (acc),
        .quo_in  (a_reg),
        .divisor (b_reg),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    assign prod_mag = {acc[31:0], a_reg};

    // Sign correction and result select, consumed on the FIN edge.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        res_hi = prod_mag[63:32];
        res_lo = prod_mag[31:0];
        if (is_div) begin
            // Division by zero yields an all-ones quotient; the remainder path
            // already reproduces the original dividend after the sign fix.
            res_lo = div_zero ? 32'hFFFF_FFFF : (neg_res ? -a_reg : a_reg);
            res_hi = neg_rem ? -acc[31:0] : acc[31:0];
        end else if (neg_res) begin
            {res_hi, res_lo} = -prod_mag;
        end
    end

    // FSM with registered handshake outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (mdu.flush) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (cnt == LAST_ITER) begin
                        state  <= FIN;
                        busy_q <= 1'b0;
                    end
                end
                FIN: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= !mdu.flush;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand latch and iteration datapath.
    // NOTE: the datapath is reset along with the FSM so the iteration counter
    // and flags start from known values; none of it forms a memory array.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
        end else if (accept) begin
            cnt      <= '0;
            is_div   <= dec.is_div;
            neg_res  <= dec.is_signed && (mdu.src1[31] ^ mdu.src2[31]);
            neg_rem  <= dec.is_signed && mdu.src1[31];
            div_zero <= dec.is_div && (mdu.src2 == 32'd0);
            acc      <= '0;
            if (dec.is_div) begin
                a_reg <= mag32(mdu.src1, dec.is_signed);
                b_reg <= mag32(mdu.src2, dec.is_signed);
            end else begin
                a_reg <= mag32(mdu.src2, dec.is_signed);
                b_reg <= mag32(mdu.src1, dec.is_signed);
            end
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                acc   <= div_rem;
                a_reg <= div_quo;
            end else begin
                acc   <= {1'b0, mul_sum[32:1]};
                a_reg <= {mul_sum[0], a_reg[31:1]};
            end
        end
    end

    // HI/LO: the operation result owns the FIN edge; MT writes land otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == FIN) begin
            if (!mdu.flush) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else begin
            if (mdu.hi_wen) hi_q <= mdu.wdata;
            if (mdu.lo_wen) lo_q <= mdu.wdata;
        end
    end

    assign mdu.req_ready = ready_q;
    assign mdu.busy      = busy_q;
    assign mdu.done      = done_q;
    assign mdu.hi        = hi_q;
    assign mdu.lo        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Self-checking bench for mul_div_unit. Inputs are driven and outputs sampled
// on the falling clock edge. Expected HI/LO come from plain 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam logic [3:0] OPC_DIV   = 4'b0001;
    localparam logic [3:0] OPC_DIVU  = 4'b0010;
    localparam logic [3:0] OPC_MULT  = 4'b0100;
    localparam logic [3:0] OPC_MULTU = 4'b1000;

    logic clk = 1'b0;
    logic resetn;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    mul_div_unit_if mdu_bus ();

    mul_div_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .mdu    (mdu_bus)
    );

    // Reference: {HI, LO} from the architectural definition of each op.
    function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[OP_DIV] || op[OP_DIVU]) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op[OP_DIV]) begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            return {a % b, a / b};
        end
        if (op[OP_MULT]) begin
            q = sa * sb;
            return q;
        end
        p = {32'd0, a} * {32'd0, b};
        return p;
    endfunction

    // Issue one request from a falling edge; return at the falling edge of
    // the done cycle. lat counts cycles from the acceptance cycle (-1: none).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi_o, output logic [31:0] lo_o, output int lat);
        mdu_bus.req_valid = 1'b1;
        mdu_bus.op        = op;
        mdu_bus.src1      = a;
        mdu_bus.src2      = b;
        @(posedge clk);
        @(negedge clk);
        mdu_bus.req_valid = 1'b0;
        mdu_bus.op        = '0;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (mdu_bus.done === 1'b1) begin
                lat = k + 1;
                break;
            end
            @(negedge clk);
        end
        hi_o = mdu_bus.hi;
        lo_o = mdu_bus.lo;
    endtask

    task automatic test_reset();
        if (mdu_bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", mdu_bus.req_ready);
        else passed++;
        total++;
        if (mdu_bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", mdu_bus.busy);
        else passed++;
        total++;
        if (mdu_bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", mdu_bus.done);
        else passed++;
        total++;
        if (mdu_bus.hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", mdu_bus.hi);
        else passed++;
        total++;
        if (mdu_bus.lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", mdu_bus.lo);
        else passed++;
        total++;
    endtask

    task automatic test_directed_case(input string name, input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] exp_hi,
                                      input logic [31:0] exp_lo);
        logic [31:0] h, l;
        int          lat;
        run_op(op, a, b, h, l, lat);
        total++;
        if (lat != 34) $display("FAIL %s_latency: got %0d want 34", name, lat);
        else passed++;
        total++;
        if (h !== exp_hi) $display("FAIL %s_hi: got %h want %h", name, h, exp_hi);
        else passed++;
        total++;
        if (l !== exp_lo) $display("FAIL %s_lo: got %h want %h", name, l, exp_lo);
        else passed++;
    endtask

    task automatic test_mul();
        test_directed_case("mult_neg1x2", OPC_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        test_directed_case("multu_maxx2", OPC_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        test_directed_case("div_m7by2", OPC_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_directed_case("divu_7by2", OPC_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        test_directed_case("div_minbym1", OPC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        test_directed_case("divu_by0", OPC_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        test_directed_case("div_neg_by0", OPC_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b, h, l;
        logic [63:0] exp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            op  = 4'($urandom_range(1, 15));
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_model(op, a, b);
            run_op(op, a, b, h, l, lat);
            total++;
            if (lat != 34) $display("FAIL rand%0d_latency: got %0d want 34", i, lat);
            else passed++;
            total++;
            if ({h, l} !== exp)
                $display("FAIL rand%0d op=%b a=%h b=%h: got %h_%h want %h_%h",
                         i, op, a, b, h, l, exp[63:32], exp[31:0]);
            else passed++;
        end
    endtask

    task automatic test_zero_op();
        mdu_bus.req_valid = 1'b1;
        mdu_bus.op        = 4'd0;
        @(negedge clk);
        mdu_bus.req_valid = 1'b0;
        total++;
        if (mdu_bus.busy !== 1'b0 || mdu_bus.req_ready !== 1'b1)
            $display("FAIL zero_op_ignored: got busy=%b ready=%b want 0/1", mdu_bus.busy, mdu_bus.req_ready);
        else passed++;
    endtask

    task automatic test_mt_write();
        mdu_bus.hi_wen = 1'b1;
        mdu_bus.wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        mdu_bus.hi_wen = 1'b0;
        mdu_bus.lo_wen = 1'b1;
        mdu_bus.wdata  = 32'hCAFE_F00D;
        total++;
        if (mdu_bus.hi !== 32'hDEAD_BEEF) $display("FAIL mthi: got %h want deadbeef", mdu_bus.hi);
        else passed++;
        @(negedge clk);
        mdu_bus.lo_wen = 1'b0;
        total++;
        if (mdu_bus.lo !== 32'hCAFE_F00D) $display("FAIL mtlo: got %h want cafef00d", mdu_bus.lo);
        else passed++;
        total++;
        if (mdu_bus.hi !== 32'hDEAD_BEEF) $display("FAIL mtlo_hi_kept: got %h want deadbeef", mdu_bus.hi);
        else passed++;
    endtask

    task automatic test_fin_write();
        logic [63:0] exp;
        exp = ref_model(OPC_MULTU, 32'h89AB_CDEF, 32'h0001_0003);
        mdu_bus.req_valid = 1'b1;
        mdu_bus.op        = OPC_MULTU;
        mdu_bus.src1      = 32'h89AB_CDEF;
        mdu_bus.src2      = 32'h0001_0003;
        @(posedge clk);
        @(negedge clk);
        mdu_bus.req_valid = 1'b0;
        repeat (32) @(negedge clk);
        total++;
        if (mdu_bus.busy !== 1'b0 || mdu_bus.req_ready !== 1'b0)
            $display("FAIL fin_state: got busy=%b ready=%b want 0/0", mdu_bus.busy, mdu_bus.req_ready);
        else passed++;
        mdu_bus.lo_wen = 1'b1;
        mdu_bus.wdata  = 32'h5A5A_5A5A;
        @(negedge clk);
        mdu_bus.lo_wen = 1'b0;
        total++;
        if (mdu_bus.done !== 1'b1) $display("FAIL fin_done: got %b want 1", mdu_bus.done);
        else passed++;
        total++;
        if (mdu_bus.lo !== exp[31:0]) $display("FAIL fin_lo_wins: got %h want %h", mdu_bus.lo, exp[31:0]);
        else passed++;
        total++;
        if (mdu_bus.hi !== exp[63:32]) $display("FAIL fin_hi: got %h want %h", mdu_bus.hi, exp[63:32]);
        else passed++;
    endtask

    task automatic test_flush();
        int seen;
        mdu_bus.hi_wen = 1'b1;
        mdu_bus.lo_wen = 1'b1;
        mdu_bus.wdata  = 32'h1111_2222;
        @(negedge clk);
        mdu_bus.hi_wen = 1'b0;
        mdu_bus.lo_wen = 1'b0;
        // Flush while idle blocks acceptance of a simultaneous request.
        mdu_bus.req_valid = 1'b1;
        mdu_bus.op        = OPC_MULTU;
        mdu_bus.src1      = 32'd3;
        mdu_bus.src2      = 32'd5;
        mdu_bus.flush     = 1'b1;
        @(negedge clk);
        mdu_bus.req_valid = 1'b0;
        mdu_bus.flush     = 1'b0;
        total++;
        if (mdu_bus.busy !== 1'b0 || mdu_bus.req_ready !== 1'b1)
            $display("FAIL flush_idle_block: got busy=%b ready=%b want 0/1", mdu_bus.busy, mdu_bus.req_ready);
        else passed++;
        // Flush in the 10th RUN cycle.
        mdu_bus.req_valid = 1'b1;
        mdu_bus.op        = OPC_DIVU;
        mdu_bus.src1      = 32'd1000;
        mdu_bus.src2      = 32'd7;
        @(posedge clk);
        @(negedge clk);
        mdu_bus.req_valid = 1'b0;
        repeat (9) @(negedge clk);
        total++;
        if (mdu_bus.busy !== 1'b1) $display("FAIL flush_run_busy: got %b want 1", mdu_bus.busy);
        else passed++;
        mdu_bus.flush = 1'b1;
        @(negedge clk);
        mdu_bus.flush = 1'b0;
        total++;
        if (mdu_bus.req_ready !== 1'b1 || mdu_bus.busy !== 1'b0)
            $display("FAIL flush_run_idle: got ready=%b busy=%b want 1/0", mdu_bus.req_ready, mdu_bus.busy);
        else passed++;
        seen = 0;
        repeat (40) begin
            if (mdu_bus.done === 1'b1) seen++;
            @(negedge clk);
        end
        total++;
        if (seen != 0) $display("FAIL flush_no_done: got %0d done pulses want 0", seen);
        else passed++;
        total++;
        if ({mdu_bus.hi, mdu_bus.lo} !== 64'h1111_2222_1111_2222)
            $display("FAIL flush_hilo_kept: got %h_%h want 11112222_11112222", mdu_bus.hi, mdu_bus.lo);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp1, exp2;
        int          lat;
        exp1 = ref_model(OPC_MULT, 32'hFFFF_FF00, 32'h0000_1234);
        exp2 = ref_model(OPC_DIV, 32'h7654_3210, 32'hFFFF_FFF3);
        mdu_bus.req_valid = 1'b1;
        mdu_bus.op        = OPC_MULT;
        mdu_bus.src1      = 32'hFFFF_FF00;
        mdu_bus.src2      = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        // Second request stays valid through the whole first operation.
        mdu_bus.op   = OPC_DIV;
        mdu_bus.src1 = 32'h7654_3210;
        mdu_bus.src2 = 32'hFFFF_FFF3;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (mdu_bus.done === 1'b1) begin
                lat = k + 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (lat != 34) $display("FAIL b2b_first_latency: got %0d want 34", lat);
        else passed++;
        total++;
        if ({mdu_bus.hi, mdu_bus.lo} !== exp1)
            $display("FAIL b2b_first: got %h_%h want %h_%h", mdu_bus.hi, mdu_bus.lo, exp1[63:32], exp1[31:0]);
        else passed++;
        total++;
        if (mdu_bus.req_ready !== 1'b1) $display("FAIL b2b_ready_in_done: got %b want 1", mdu_bus.req_ready);
        else passed++;
        @(negedge clk);
        mdu_bus.req_valid = 1'b0;
        mdu_bus.op        = '0;
        total++;
        if (mdu_bus.busy !== 1'b1) $display("FAIL b2b_second_accepted: got busy=%b want 1", mdu_bus.busy);
        else passed++;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (mdu_bus.done === 1'b1) begin
                lat = k + 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (lat != 34) $display("FAIL b2b_second_latency: got %0d want 34", lat);
        else passed++;
        total++;
        if ({mdu_bus.hi, mdu_bus.lo} !== exp2)
            $display("FAIL b2b_second: got %h_%h want %h_%h", mdu_bus.hi, mdu_bus.lo, exp2[63:32], exp2[31:0]);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        mdu_bus.hi_wen = 1'b1;
        mdu_bus.wdata  = 32'hABCD_0123;
        @(negedge clk);
        mdu_bus.hi_wen    = 1'b0;
        mdu_bus.req_valid = 1'b1;
        mdu_bus.op        = OPC_MULT;
        mdu_bus.src1      = 32'd12345;
        mdu_bus.src2      = 32'd678;
        @(posedge clk);
        @(negedge clk);
        mdu_bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        total++;
        if (mdu_bus.hi !== 32'd0 || mdu_bus.lo !== 32'd0)
            $display("FAIL rst_mid_hilo: got %h_%h want 0_0", mdu_bus.hi, mdu_bus.lo);
        else passed++;
        total++;
        if (mdu_bus.req_ready !== 1'b1 || mdu_bus.busy !== 1'b0)
            $display("FAIL rst_mid_idle: got ready=%b busy=%b want 1/0", mdu_bus.req_ready, mdu_bus.busy);
        else passed++;
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (40) begin
            if (mdu_bus.done === 1'b1) seen++;
            @(negedge clk);
        end
        total++;
        if (seen != 0) $display("FAIL rst_mid_no_done: got %0d done pulses want 0", seen);
        else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn            = 1'b0;
        mdu_bus.req_valid = 1'b0;
        mdu_bus.op        = '0;
        mdu_bus.src1      = '0;
        mdu_bus.src2      = '0;
        mdu_bus.flush     = 1'b0;
        mdu_bus.hi_wen    = 1'b0;
        mdu_bus.lo_wen    = 1'b0;
        mdu_bus.wdata     = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        test_reset();
        test_mul();
        test_div();
        test_zero_op();
        test_mt_write();
        test_fin_write();
        test_flush();
        test_random();
        test_back_to_back();
        test_reset_mid_run();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
